slv_port: RTL

- Slave-side endpoint directly downstream of the 2x2 crossbar; one instance per crossbar output (`cross_to_slv[i]`).
- Captures a master request and sequences it through CMD, ADDR, DATA and RESP phases against an internal word memory.
- Returns read data and status as `t_slv` to the crossbar read path (`rd_to_cross[i]`).
- Publishes its current phase as `t_st`; the crossbar's 00/11 arbitration uses this phase (CMD, ADDR) to alternate masters.

---
 rtl/slv_port_pkg.sv | 33 +++
 rtl/slv_mem.sv | 31 +++
 rtl/slv_port.sv | 122 ++++++++++++
 3 files changed

// File: rtl/slv_port_pkg.sv
// Shared types for the crossbar slave endpoint.
//   t_mst : request from the crossbar (valid, we, addr, wdata)
//   t_slv : response to the crossbar read path (ack, err, rdata)
//   t_st  : published transaction phase
package slv_port_pkg;

  localparam int unsigned DW      = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ST_W    = 3;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     wdata;
  } t_mst;

  typedef struct packed {
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;
  } t_slv;

  // CMD/ADDR are the names the crossbar arbiter already keys on.
  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } t_st;

endpackage

// File: rtl/slv_mem.sv
// Single-port 2**AW x 32 synchronous RAM with registered read.
//   clk   : clock
//   we    : write enable, index/wdata sampled on the rising edge
//   re    : read enable, rdata loads mem[index] on the rising edge
//   index : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module slv_mem
  import slv_port_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
    if (re) rdata      <= mem[index];
  end

endmodule

// File: rtl/slv_port.sv
// Slave-side endpoint behind one crossbar output. Captures a request and
// walks it through CMD, ADDR, DATA and RESP against a local word memory.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   req   : request from the crossbar (t_mst)
//   rsp   : registered response, ack is a one-cycle pulse in RESP (t_slv)
//   st    : registered current phase (t_st)
//   busy  : registered, high in every phase except IDLE
module slv_port
  import slv_port_pkg::*;
#(
  parameter int unsigned AW     = 6,
  parameter bit          SLV_ID = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  t_mst req,
  output t_slv rsp,
  output t_st  st,
  output logic busy
);

  t_st           st_q;
  t_st           st_n;
  logic          busy_n;
  t_slv          rsp_n;

  logic          cap_c;
  logic          we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic          err_c;
  logic [AW-1:0] idx_q;

  logic          mem_we_c;
  logic          mem_re_c;
  logic [DW-1:0] mem_rdata;

  // Request decode: wrong slave, misaligned, or beyond the local memory.
  assign err_c = (addr_q[ADDR_W-1] != SLV_ID)
               | (addr_q[1:0] != 2'b00)
               | (addr_q[ADDR_W-2:AW+2] != '0);

  // State, outputs and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      busy    <= 1'b0;
      rsp     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      st_q <= st_n;
      busy <= busy_n;
      rsp  <= rsp_n;
      if (cap_c) begin
        we_q    <= req.we;
        addr_q  <= req.addr;
        wdata_q <= req.wdata;
      end
      if (st_q == CMD) begin
        err_q <= err_c;
        idx_q <= addr_q[AW+1:2];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    st_n      = st_q;
    rsp_n     = rsp;
    rsp_n.ack = 1'b0;
    cap_c     = 1'b0;
    mem_we_c  = 1'b0;
    mem_re_c  = 1'b0;

    case (st_q)
      IDLE: begin
        if (req.valid) begin
          cap_c = 1'b1;
          st_n  = CMD;
        end
      end
      CMD:  st_n = ADDR;
      ADDR: begin
        // Read issued one phase early so the registered RAM output is
        // ready to drop into the response register on the DATA edge.
        mem_re_c = !we_q && !err_q;
        st_n     = DATA;
      end
      DATA: begin
        mem_we_c    = we_q && !err_q;
        rsp_n.ack   = 1'b1;
        rsp_n.err   = err_q;
        rsp_n.rdata = (!we_q && !err_q) ? mem_rdata : '0;
        st_n        = RESP;
      end
      RESP:    st_n = IDLE;
      default: st_n = IDLE;
    endcase

    busy_n = (st_n != IDLE);
  end

  assign st = st_q;

  slv_mem #(
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
